// File: rtl/axi_stb_m.sv
// axi_stb_m - burst-store master.
//
// Accepts a store command (source address on the UR side, destination
// address, beat count). For each beat it reads one 128-bit word through the
// AXI read master port, then writes that word to the destination through the
// AXI write master port. Only one beat is in flight at a time. Completion,
// including an abort on an error response, is signalled by a one-cycle done
// pulse with done_err qualifying it.
//
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (cmd_ready only while idle)
//   cmd_src_addr         UR-side byte start address (+SRC_STRIDE per beat)
//   cmd_dst_addr         destination byte start address (+DST_STRIDE per beat)
//   cmd_len              beat count (0 = complete immediately, no traffic)
//   busy                 a command is in progress
//   done, done_err       one-cycle completion pulse, error qualifier
//   m_ar*/m_r*           AXI read address / read data channels
//   m_aw*/m_w*/m_b*      AXI write address / write data / write response
module axi_stb_m #(
  parameter int unsigned SRC_STRIDE = 4,
  parameter int unsigned DST_STRIDE = 16,
  parameter int unsigned LEN_W      = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_src_addr,
  input  logic [31:0]      cmd_dst_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             busy,
  output logic             done,
  output logic             done_err,
  output logic [31:0]      m_araddr,
  output logic             m_arvalid,
  input  logic             m_arready,
  input  logic [127:0]     m_rdata,
  input  logic [1:0]       m_rresp,
  input  logic             m_rvalid,
  output logic             m_rready,
  output logic [31:0]      m_awaddr,
  output logic             m_awvalid,
  input  logic             m_awready,
  output logic [127:0]     m_wdata,
  output logic [15:0]      m_wstrb,
  output logic             m_wvalid,
  input  logic             m_wready,
  input  logic [1:0]       m_bresp,
  input  logic             m_bvalid,
  output logic             m_bready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR,
    S_WR_RESP,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [31:0]      r_araddr;
  logic [31:0]      r_awaddr;
  logic [127:0]     r_wdata;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_beat;
  logic             r_aw_done;
  logic             r_w_done;
  logic             r_err;
  logic             r_done;
  logic             r_done_err;

  logic [LEN_W-1:0] w_beat_inc;
  logic             w_accept;
  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_wr_fin;
  logic             w_r_hs;
  logic             w_b_hs;

  assign w_beat_inc = r_beat + LEN_W'(1);
  assign w_accept   = (r_state == S_IDLE) && cmd_valid;
  assign w_aw_hs    = (r_state == S_WR) && !r_aw_done && m_awready;
  assign w_w_hs     = (r_state == S_WR) && !r_w_done && m_wready;
  // Both write channels finished: either earlier or on this very edge.
  assign w_wr_fin   = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
  assign w_r_hs     = (r_state == S_RD_DATA) && m_rvalid;
  assign w_b_hs     = (r_state == S_WR_RESP) && m_bvalid;

  assign m_araddr = r_araddr;
  assign m_awaddr = r_awaddr;
  assign m_wdata  = r_wdata;
  assign m_wstrb  = '1;
  assign done     = r_done;
  assign done_err = r_done_err;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Valids/readies decode straight from the state register so an
  // asynchronous reset removes them in the same instant.
  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          w_next = (cmd_len == '0) ? S_DONE : S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          w_next = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        m_rready = 1'b1;
        if (m_rvalid) begin
          w_next = (m_rresp != 2'b00) ? S_DONE : S_WR;
        end
      end
      S_WR: begin
        m_awvalid = !r_aw_done;
        m_wvalid  = !r_w_done;
        if (w_wr_fin) begin
          w_next = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          if (m_bresp != 2'b00 || w_beat_inc == r_len) begin
            w_next = S_DONE;
          end else begin
            w_next = S_RD_ADDR;
          end
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Addresses are kept as running sums (stride added per completed beat)
  // rather than start + beat*stride; the result is identical modulo 2^32.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_araddr   <= '0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_len      <= '0;
      r_beat     <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
      r_done_err <= 1'b0;
    end else begin
      // done is registered off the DONE state, so it appears the cycle
      // after DONE (two cycles after accepting a zero-length command).
      r_done     <= (r_state == S_DONE);
      r_done_err <= (r_state == S_DONE) && r_err;

      if (w_accept) begin
        r_araddr <= cmd_src_addr;
        r_awaddr <= cmd_dst_addr;
        r_len    <= cmd_len;
        r_beat   <= '0;
        r_err    <= 1'b0;
      end

      if (w_r_hs) begin
        r_wdata <= m_rdata;
        if (m_rresp != 2'b00) begin
          r_err <= 1'b1;
        end
      end

      if (r_state == S_WR) begin
        if (w_wr_fin) begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end else begin
          r_aw_done <= r_aw_done || w_aw_hs;
          r_w_done  <= r_w_done || w_w_hs;
        end
      end

      if (w_b_hs) begin
        if (m_bresp != 2'b00) begin
          r_err <= 1'b1;
        end else begin
          r_beat   <= w_beat_inc;
          r_araddr <= r_araddr + 32'(SRC_STRIDE);
          r_awaddr <= r_awaddr + 32'(DST_STRIDE);
        end
      end

      if (r_state == S_DONE) begin
        r_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_stb_m.sv
module tb_axi_stb_m;

  logic         aclk;
  logic         aresetn;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [31:0]  cmd_src_addr;
  logic [31:0]  cmd_dst_addr;
  logic [7:0]   cmd_len;
  logic         busy;
  logic         done;
  logic         done_err;
  logic [31:0]  m_araddr;
  logic         m_arvalid;
  logic         m_arready;
  logic [127:0] m_rdata;
  logic [1:0]   m_rresp;
  logic         m_rvalid;
  logic         m_rready;
  logic [31:0]  m_awaddr;
  logic         m_awvalid;
  logic         m_awready;
  logic [127:0] m_wdata;
  logic [15:0]  m_wstrb;
  logic         m_wvalid;
  logic         m_wready;
  logic [1:0]   m_bresp;
  logic         m_bvalid;
  logic         m_bready;

  axi_stb_m #(
    .SRC_STRIDE(4),
    .DST_STRIDE(16),
    .LEN_W(8)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr), .cmd_len(cmd_len),
    .busy(busy), .done(done), .done_err(done_err),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } aw_t;

  logic [31:0]  exp_ar[$];
  aw_t          exp_aw[$];
  logic [127:0] exp_w[$];
  logic         exp_done[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int acc_cyc = 0;

  // slave controls
  int rd_beat = 0;
  int err_beat = -1;
  int aw_hold = 0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  function automatic logic [127:0] rd(input logic [31:0] a);
    return {a ^ 32'h1111_1111, ~a, a + 32'h0000_0007, 32'hC0DE_0000 | {16'h0, a[15:0]}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [127:0] act);
    checks++;
    errors++;
    $display("FAIL %s unexpected act=%h exp=none", name, act);
  endtask

  // Slave model: captures handshakes at the negedge, updates its drives
  // just after the following posedge.
  initial begin
    bit s_ar, s_r, s_aw, s_w, s_b, aw_got, w_got;
    logic [31:0] s_addr;
    m_arready = 1'b1; m_wready = 1'b1; m_awready = 1'b1;
    m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
    m_bvalid = 1'b0; m_bresp = '0;
    aw_got = 0; w_got = 0;
    forever begin
      @(negedge aclk);
      s_ar = m_arvalid && m_arready; s_addr = m_araddr;
      s_r  = m_rvalid && m_rready;
      s_aw = m_awvalid && m_awready;
      s_w  = m_wvalid && m_wready;
      s_b  = m_bvalid && m_bready;
      @(posedge aclk); #1;
      if (!aresetn) begin
        m_rvalid = 1'b0; m_bvalid = 1'b0; m_awready = 1'b1;
        aw_got = 0; w_got = 0;
      end else begin
        if (s_r) m_rvalid = 1'b0;
        if (s_ar) begin
          m_rvalid = 1'b1;
          m_rdata  = rd(s_addr);
          m_rresp  = (rd_beat == err_beat) ? 2'b10 : 2'b00;
          rd_beat++;
        end
        if (s_aw) aw_got = 1;
        if (s_w) w_got = 1;
        if (s_b) m_bvalid = 1'b0;
        if (aw_got && w_got) begin
          m_bvalid = 1'b1; m_bresp = 2'b00; aw_got = 0; w_got = 0;
        end
        if (m_awvalid && aw_hold > 0) begin
          m_awready = 1'b0; aw_hold--;
        end else begin
          m_awready = 1'b1;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    int aw_cnt, w_cnt;
    aw_t e;
    aw_cnt = 0; w_cnt = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        aw_cnt = 0; w_cnt = 0;
      end else begin
        if (m_arvalid && m_arready) begin
          if (exp_ar.size() == 0) unexpected("ar", m_araddr);
          else chk("araddr", m_araddr, exp_ar.pop_front());
        end
        if (m_awvalid) begin
          aw_cnt++;
          if (exp_aw.size() == 0) unexpected("aw", m_awaddr);
          else chk("awaddr_stable", m_awaddr, exp_aw[0].addr);
          if (m_awready && exp_aw.size() != 0) begin
            e = exp_aw.pop_front();
            chk("aw_cycles", aw_cnt, e.cyc);
            aw_cnt = 0;
          end
        end
        if (m_wvalid) begin
          w_cnt++;
          if (m_wready) begin
            chk("w_cycles", w_cnt, 1);
            chk("wstrb", m_wstrb, 16'hFFFF);
            if (exp_w.size() == 0) unexpected("w", m_wdata);
            else chk("wdata", m_wdata, exp_w.pop_front());
            w_cnt = 0;
          end
        end
        if (m_bready) chk("b_after_aw_w", {m_awvalid, m_wvalid}, 2'b00);
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          if (exp_done.size() == 0) unexpected("done", done_err);
          else chk("done_err", done_err, exp_done.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic [31:0] src, input logic [31:0] dst,
                       input int len, input int errb, input int awh);
    aw_t e;
    for (int i = 0; i < len; i++) begin
      exp_ar.push_back(src + 32'(i * 4));
      if (i == errb) break;
      e.addr = dst + 32'(i * 16);
      e.cyc  = (i == 0 && awh > 0) ? awh + 1 : 1;
      exp_aw.push_back(e);
      exp_w.push_back(rd(src + 32'(i * 4)));
    end
    exp_done.push_back(errb >= 0 && errb < len);
    rd_beat = 0; err_beat = errb; aw_hold = awh;
    @(posedge aclk); #1;
    cmd_valid = 1'b1; cmd_src_addr = src; cmd_dst_addr = dst; cmd_len = 8'(len);
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (cmd_ready) break;
    end
    acc_cyc = cyc;
    chk("cmd_ready", cmd_ready, 1'b1);
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 300 && done_cnt == d0; i++) @(negedge aclk);
    if (done_cnt == d0) begin
      checks++; errors++;
      $display("FAIL %s done timeout act=none exp=done", name);
    end
    @(negedge aclk);
    chk({name, "_pulse"}, done, 1'b0);
    chk({name, "_drained"}, exp_ar.size() + exp_aw.size() + exp_w.size() + exp_done.size(), 0);
  endtask

  initial begin
    int d0;
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_src_addr = '0; cmd_dst_addr = '0; cmd_len = '0;
    #12;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_ctl", {busy, done, done_err, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}, 8'h00);
    chk("rst_regs", {m_araddr, m_awaddr}, 64'h0);
    chk("rst_wdata", m_wdata, 128'h0);
    #20 aresetn = 1'b1;

    issue(32'h100, 32'h8000, 1, -1, 0);
    wait_done("single");

    issue(32'h40, 32'h1000, 4, -1, 0);
    wait_done("burst");

    issue(32'h200, 32'h2000, 1, -1, 3);
    wait_done("backpressure");

    issue(32'h300, 32'h3000, 4, 1, 0);
    wait_done("error");
    issue(32'h400, 32'h4000, 1, -1, 0);
    wait_done("after_error");

    issue(32'h500, 32'h5000, 0, -1, 0);
    wait_done("len0");
    chk("len0_latency", done_cyc - acc_cyc, 2);

    issue(32'hFFFF_FFFC, 32'hFFFF_FFF0, 2, -1, 0);
    wait_done("wrap");

    // Reset during the write phase of beat 1
    d0 = done_cnt;
    issue(32'h600, 32'h6000, 2, -1, 0);
    for (int i = 0; i < 50 && !m_bready; i++) @(negedge aclk);
    for (int i = 0; i < 50 && !m_awvalid; i++) @(negedge aclk);
    chk("rst_mid_in_wr", m_awvalid, 1'b1);
    #2 aresetn = 1'b0;
    #1;
    chk("rst_mid_valids", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, busy, done}, 7'h00);
    exp_ar.delete(); exp_aw.delete(); exp_w.delete(); exp_done.delete();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (4) @(negedge aclk);
    chk("rst_mid_no_done", done_cnt, d0);
    chk("rst_mid_cmd_ready", cmd_ready, 1'b1);
    issue(32'h700, 32'h7000, 1, -1, 0);
    wait_done("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
